// File: rtl/laser_pulse_sequencer.sv
// laser_pulse_sequencer
//   Drives a shared down-counting timer to fire a train of NPulses laser
//   pulses, each OnLen cycles long, separated by OffLen-cycle gaps.
//   The timer is external: this block supplies its enable/reload/load value
//   and reacts to its terminal-count pulse.
//
// Ports
//   Clk         system clock, rising edge
//   Rst         synchronous active-high reset
//   B           start button (rising edge starts a run)
//   Abort       synchronous kill, returns to IDLE without Done
//   OnLen       laser-on cycles per pulse (0 never starts a run)
//   OffLen      gap cycles between pulses (0 merges pulses)
//   NPulses     pulses per run (0 never starts a run)
//   ZPulse      timer terminal-count pulse
//   Et, Rt      timer enable / reload (reload wins)
//   TmrVal      timer load value
//   X           laser drive
//   Busy        high while a train is in progress (ON or GAP)
//   Done        one-cycle strobe after the last ON cycle
//   PulsesLeft  pulses remaining, current one included
module laser_pulse_sequencer #(
    parameter int NBits = 8,
    parameter int CBits = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             B,
    input  logic             Abort,
    input  logic [NBits-1:0] OnLen,
    input  logic [NBits-1:0] OffLen,
    input  logic [CBits-1:0] NPulses,
    input  logic             ZPulse,
    output logic             Et,
    output logic             Rt,
    output logic [NBits-1:0] TmrVal,
    output logic             X,
    output logic             Busy,
    output logic             Done,
    output logic [CBits-1:0] PulsesLeft
);

    typedef enum logic [1:0] {IDLE, ON, GAP, DONE} state_t;

    localparam logic [NBits-1:0] ONE_N = NBits'(1);
    localparam logic [CBits-1:0] ONE_C = CBits'(1);

    state_t           state;
    logic             bprev;
    logic [NBits-1:0] on_sh;
    logic [NBits-1:0] off_sh;
    logic [CBits-1:0] left;
    logic             start;
    logic             last;

    // bprev resets high so a button held through reset is not seen as an edge.
    assign start = B & ~bprev & (NPulses != '0) & (OnLen != '0);
    assign last  = (left == ONE_C);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= IDLE;
            bprev  <= 1'b1;
            left   <= '0;
            on_sh  <= '0;
            off_sh <= '0;
        end else begin
            bprev <= B;
            if (Abort) begin
                state <= IDLE;
                left  <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        on_sh  <= OnLen;
                        off_sh <= OffLen;
                        left   <= NPulses;
                        state  <= ON;
                    end
                    ON: if (ZPulse) begin
                        if (last) begin
                            left  <= '0;
                            state <= DONE;
                        end else begin
                            left  <= left - ONE_C;
                            // zero gap: reload on-time and keep X high
                            state <= (off_sh != '0) ? GAP : ON;
                        end
                    end
                    GAP: if (ZPulse) state <= ON;
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Timer controls are Mealy on ZPulse so the next segment's length is
    // loaded on the same edge that ends the current one.
    always_comb begin
        Et     = 1'b0;
        Rt     = 1'b1;
        X      = 1'b0;
        TmrVal = on_sh - ONE_N;
        case (state)
            IDLE: begin
                TmrVal = OnLen - ONE_N;
            end
            ON: begin
                X  = 1'b1;
                Et = 1'b1;
                Rt = ZPulse & ~last;
                if (off_sh != '0) TmrVal = off_sh - ONE_N;
            end
            GAP: begin
                Et = 1'b1;
                Rt = ZPulse;
            end
            default: ;
        endcase
    end

    assign Busy       = (state == ON) || (state == GAP);
    assign Done       = (state == DONE);
    assign PulsesLeft = left;

endmodule

// File: tb/tb_laser_pulse_sequencer.sv
module tb_laser_pulse_sequencer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       B = 1'b1;
    logic       Abort = 1'b0;
    logic [7:0] OnLen = 8'd16;
    logic [7:0] OffLen = 8'd0;
    logic [3:0] NPulses = 4'd1;
    logic       ZPulse;
    logic       Et, Rt, X, Busy, Done;
    logic [7:0] TmrVal;
    logic [3:0] PulsesLeft;

    laser_pulse_sequencer #(.NBits(8), .CBits(4)) dut (
        .Clk(Clk), .Rst(Rst), .B(B), .Abort(Abort),
        .OnLen(OnLen), .OffLen(OffLen), .NPulses(NPulses),
        .ZPulse(ZPulse), .Et(Et), .Rt(Rt), .TmrVal(TmrVal),
        .X(X), .Busy(Busy), .Done(Done), .PulsesLeft(PulsesLeft)
    );

    always #5 Clk = ~Clk;

    // Environment: the shared countdown timer.
    logic [7:0] cnt = 8'd0;
    always @(posedge Clk) begin
        if (Rt) cnt <= TmrVal;
        else if (Et) cnt <= cnt - 8'd1;
    end
    assign ZPulse = Et & (cnt == 8'd0);

    // Reference model: on a start, the whole run is expanded into a list of
    // per-cycle expectations from OnLen/OffLen/NPulses. Empty list = idle.
    typedef struct packed {
        logic       x;
        logic       busy;
        logic       done;
        logic       rt;
        logic [3:0] pl;
    } ent_t;

    ent_t  q[$];
    logic  bprev_m = 1'b1;
    bit    mvalid = 0;
    int    vectors = 0;
    int    miscompares = 0;
    string phase = "reset";

    function automatic void build(input int on, input int off, input int n);
        ent_t e;
        q.delete();
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < on; i++) begin
                e.x = 1'b1; e.busy = 1'b1; e.done = 1'b0;
                e.rt = (i == on - 1) && (p != n - 1);
                e.pl = 4'(n - p);
                q.push_back(e);
            end
            if (p != n - 1) begin
                for (int i = 0; i < off; i++) begin
                    e.x = 1'b0; e.busy = 1'b1; e.done = 1'b0;
                    e.rt = (i == off - 1);
                    e.pl = 4'(n - p - 1);
                    q.push_back(e);
                end
            end
        end
        e.x = 1'b0; e.busy = 1'b0; e.done = 1'b1; e.rt = 1'b1; e.pl = 4'd0;
        q.push_back(e);
    endfunction

    task automatic cycle();
        ent_t       e;
        logic [8:0] expv, obsv;
        bit         idle_now;
        @(negedge Clk);
        idle_now = (q.size() == 0);
        if (mvalid) begin
            if (idle_now) begin
                e.x = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.rt = 1'b1; e.pl = 4'd0;
            end else begin
                e = q[0];
            end
            expv = {e.x, e.busy, e.rt, e.busy, e.done, e.pl};
            obsv = {X, Et, Rt, Busy, Done, PulsesLeft};
            vectors++;
            assert (obsv === expv) else begin
                miscompares++;
                $error("FAIL %s {X,Et,Rt,Busy,Done,PL}: got %b expected %b", phase, obsv, expv);
            end
            if (idle_now) begin
                vectors++;
                assert (TmrVal === OnLen - 8'd1) else begin
                    miscompares++;
                    $error("FAIL %s idle TmrVal: got %0d expected %0d", phase, TmrVal, OnLen - 8'd1);
                end
            end
        end
        if (!idle_now) void'(q.pop_front());
        if (Rst) begin
            q.delete();
            bprev_m = 1'b1;
            mvalid = 1;
        end else begin
            if (Abort) q.delete();
            else if (idle_now && B && !bprev_m && NPulses != 0 && OnLen != 0)
                build(int'(OnLen), int'(OffLen), int'(NPulses));
            bprev_m = B;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic press();
        B = 1'b0; cycle();
        B = 1'b1; cycle();
        B = 1'b0;
    endtask

    initial begin
        // Reset with B held high; no start after release while B stays high.
        phase = "reset";
        cycles(3);
        Rst = 1'b0;
        phase = "b_held_after_reset";
        cycles(4);

        phase = "single16";
        OnLen = 8'd16; NPulses = 4'd1; OffLen = 8'd0;
        press();
        cycles(24);

        phase = "3x3_gap2";
        OnLen = 8'd3; OffLen = 8'd2; NPulses = 4'd3;
        press();
        cycles(16);

        phase = "merged4x2";
        OnLen = 8'd4; OffLen = 8'd0; NPulses = 4'd2;
        press();
        cycles(11);

        // Edge cycle t, then t+1..t+8, abort sampled in t+9 (2nd cycle of 2nd gap).
        phase = "abort_gap";
        OnLen = 8'd2; OffLen = 8'd3; NPulses = 4'd3;
        B = 1'b0; cycle();
        B = 1'b1; cycle();
        B = 1'b0; cycles(8);
        Abort = 1'b1; cycle();
        Abort = 1'b0; cycles(5);
        phase = "restart_after_abort";
        press();
        cycles(20);

        // B held high through end of run: no restart until new edge.
        phase = "b_held_end";
        OnLen = 8'd2; OffLen = 8'd1; NPulses = 4'd2;
        B = 1'b0; cycle();
        B = 1'b1; cycles(12);
        B = 1'b0; cycle();
        B = 1'b1; cycles(9);
        B = 1'b0;

        phase = "illegal";
        NPulses = 4'd0; OnLen = 8'd5;
        press(); cycles(3);
        NPulses = 4'd2; OnLen = 8'd0;
        press(); cycles(3);

        phase = "change_during_on";
        OnLen = 8'd5; OffLen = 8'd2; NPulses = 4'd2;
        press();
        OnLen = 8'd1; NPulses = 4'd7; OffLen = 8'd0;
        B = 1'b1; cycle(); B = 1'b0; cycle(); B = 1'b1; cycle(); B = 1'b0;
        cycles(15);

        phase = "random";
        for (int r = 0; r < 60; r++) begin
            OnLen   = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            OffLen  = 8'($urandom_range(0, 4));
            NPulses = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom_range(1, 4));
            press();
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 7) == 0) B = ~B;
                if ($urandom_range(0, 5) == 0) OnLen = 8'($urandom_range(0, 6));
                if ($urandom_range(0, 5) == 0) NPulses = 4'($urandom_range(0, 4));
                if ($urandom_range(0, 5) == 0) OffLen = 8'($urandom_range(0, 4));
                Abort = ($urandom_range(0, 39) == 0);
                Rst = ($urandom_range(0, 199) == 0);
                cycle();
                Abort = 1'b0;
                Rst = 1'b0;
            end
        end
        cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
